// File: rtl/rx_header_decoder.sv
// rx_header_decoder: receive-side FEC-1/3 packet header decoder.
// Takes 54 hard-decision bits (18 tripled bits) after the access-code trailer.
// Each triplet is majority-voted, dewhitened, run through the HEC divider and
// captured into the LT_ADDR/TYPE/FLOW/ARQN/SEQN shadow fields. At the end of
// the header the fields are committed only if the HEC remainder is zero.
// Optional feature: define RXHDR_FEC_STAT_EN to build the per-header count of
// triplets that needed correction (fec_corr_cnt). Without it the output is 0.
module rx_header_decoder #(
    parameter logic [7:0] HEC_POLY = 8'hA7,  // D^8+D^7+D^5+D^2+D+1, low 8 bits
    parameter logic [6:0] WHT_POLY = 7'h11,  // x^7+x^4+1 feedback taps
    parameter int         NBITS    = 18      // 10 header bits + 8 HEC bits
) (
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       p_1us,
    input  logic       hdr_start_p,
    input  logic       abort,
    input  logic       rxbit,
    input  logic       dewhiten_en,
    input  logic [5:0] clk_seed,
    input  logic [7:0] uap,
    output logic       busy,
    output logic [2:0] dec_lt_addr,
    output logic [3:0] dec_pk_type,
    output logic       dec_flow,
    output logic       dec_arqn,
    output logic       dec_seqn,
    output logic       hec_ok,
    output logic       hdr_done_p,
    output logic       hec_err_p,
    output logic [4:0] fec_corr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_HEC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index of the last header-field bit and of the last HEC bit.
    localparam logic [4:0] HDR_LAST = 5'd9;
    localparam logic [4:0] HEC_LAST = 5'(NBITS - 1);

    state_t     state;
    state_t     state_nxt;

    // Event qualifiers
    logic       start_ev;    // accepted header start (abort has priority)
    logic       strobe_ev;   // data-carrying bit strobe while receiving
    logic       third_ev;    // strobe that completes a triplet

    // Triplet collection
    logic [1:0] trip_cnt;
    logic       samp0;
    logic       samp1;
    logic       maj;
    logic       bit_vld;     // decoded bit waiting to be processed
    logic       bit_maj;     // registered majority decision

    // Per-bit decode path
    logic [4:0] bit_idx;
    logic [6:0] wreg;        // whitening LFSR, stage 6 is the output
    logic [7:0] hreg;        // HEC divider remainder
    logic       wht_en;      // dewhiten_en captured at start
    logic       d_bit;       // dewhitened decoded bit
    logic       hec_fb;
    logic [9:0] shadow;      // header bits 0..9, LSB first

    assign busy      = (state == S_HDR) || (state == S_HEC);
    assign start_ev  = hdr_start_p & p_1us & ~abort;
    assign strobe_ev = p_1us & busy & ~abort & ~hdr_start_p;
    assign third_ev  = strobe_ev & (trip_cnt == 2'd2);

    // Majority of the two latched samples and the live third sample.
    assign maj    = (samp0 & samp1) | (samp0 & rxbit) | (samp1 & rxbit);
    assign d_bit  = bit_maj ^ (wht_en & wreg[6]);
    assign hec_fb = hreg[7] ^ d_bit;

    // State register.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort beats start, start beats normal sequencing.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt (no latch).
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else if (start_ev) begin
            state_nxt = S_HDR;
        end else begin
            case (state)
                S_HDR: begin
                    if (bit_vld && (bit_idx == HDR_LAST)) begin
                        state_nxt = S_HEC;
                    end
                end
                S_HEC: begin
                    if (bit_vld && (bit_idx == HEC_LAST)) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Collect three samples per bit and register the majority decision.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            trip_cnt <= 2'd0;
            samp0    <= 1'b0;
            samp1    <= 1'b0;
            bit_vld  <= 1'b0;
            bit_maj  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere in clocked blocks; later reads in this
            // block see the pre-edge values, which is what the pipeline relies on.
            bit_vld <= 1'b0;
            if (abort || start_ev) begin
                trip_cnt <= 2'd0;
            end else if (strobe_ev) begin
                case (trip_cnt)
                    2'd0: begin
                        samp0    <= rxbit;
                        trip_cnt <= 2'd1;
                    end
                    2'd1: begin
                        samp1    <= rxbit;
                        trip_cnt <= 2'd2;
                    end
                    default: begin
                        bit_maj  <= maj;
                        bit_vld  <= 1'b1;
                        trip_cnt <= 2'd0;
                    end
                endcase
            end
        end
    end

    // Dewhiten, divide and capture each decoded bit; reload on header start.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            wreg    <= 7'h00;
            hreg    <= 8'h00;
            wht_en  <= 1'b0;
            bit_idx <= 5'd0;
            shadow  <= 10'd0;
        end else if (start_ev) begin
            wreg    <= {clk_seed, 1'b1};
            hreg    <= uap;
            wht_en  <= dewhiten_en;
            bit_idx <= 5'd0;
            shadow  <= 10'd0;
        end else if (bit_vld && busy && !abort) begin
            // Whitening keeps running through the HEC bits as well.
            wreg <= {wreg[5:0], 1'b0} ^ (wreg[6] ? WHT_POLY : 7'h00);
            // HEC is received MSB first, so a clean header leaves a zero remainder.
            hreg <= {hreg[6:0], 1'b0} ^ (hec_fb ? HEC_POLY : 8'h00);
            if (bit_idx <= HDR_LAST) begin
                shadow[bit_idx[3:0]] <= d_bit;
            end
            bit_idx <= bit_idx + 5'd1;
        end
    end

    // Commit fields and pulse the verdict in the single DONE cycle.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            dec_lt_addr <= 3'd0;
            dec_pk_type <= 4'd0;
            dec_flow    <= 1'b0;
            dec_arqn    <= 1'b0;
            dec_seqn    <= 1'b0;
            hec_ok      <= 1'b0;
            hdr_done_p  <= 1'b0;
            hec_err_p   <= 1'b0;
        end else begin
            hdr_done_p <= 1'b0;
            hec_err_p  <= 1'b0;
            if ((state == S_DONE) && !abort) begin
                hec_ok <= (hreg == 8'h00);
                if (hreg == 8'h00) begin
                    dec_lt_addr <= shadow[2:0];
                    dec_pk_type <= shadow[6:3];
                    dec_flow    <= shadow[7];
                    dec_arqn    <= shadow[8];
                    dec_seqn    <= shadow[9];
                    hdr_done_p  <= 1'b1;
                end else begin
                    // Bad HEC: previous committed fields stay valid.
                    hec_err_p <= 1'b1;
                end
            end
        end
    end

`ifdef RXHDR_FEC_STAT_EN
    logic       trip_mixed;  // the three samples of a triplet disagree
    logic [4:0] corr_cnt;

    assign trip_mixed = ~((samp0 == samp1) && (samp1 == rxbit));

    // Count corrected triplets, saturating at one per decoded bit.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            corr_cnt <= 5'd0;
        end else if (start_ev) begin
            corr_cnt <= 5'd0;
        end else if (third_ev && trip_mixed && (corr_cnt != 5'(NBITS))) begin
            corr_cnt <= corr_cnt + 5'd1;
        end
    end

    assign fec_corr_cnt = corr_cnt;
`else
    assign fec_corr_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_rx_header_decoder.sv
// tb_rx_header_decoder: directed self-checking bench for rx_header_decoder.
// A small transmit model builds the 54 tripled (optionally whitened) samples
// of a header with its HEC; expected field values are hand-written constants.
`timescale 1ns / 1ps
module tb_rx_header_decoder;

    logic       clk_6M = 1'b0;
    logic       rst;
    logic       p_1us;
    logic       hdr_start_p;
    logic       abort;
    logic       rxbit;
    logic       dewhiten_en;
    logic [5:0] clk_seed;
    logic [7:0] uap;
    logic       busy;
    logic [2:0] dec_lt_addr;
    logic [3:0] dec_pk_type;
    logic       dec_flow;
    logic       dec_arqn;
    logic       dec_seqn;
    logic       hec_ok;
    logic       hdr_done_p;
    logic       hec_err_p;
    logic [4:0] fec_corr_cnt;

    rx_header_decoder dut (
        .clk_6M      (clk_6M),
        .rst         (rst),
        .p_1us       (p_1us),
        .hdr_start_p (hdr_start_p),
        .abort       (abort),
        .rxbit       (rxbit),
        .dewhiten_en (dewhiten_en),
        .clk_seed    (clk_seed),
        .uap         (uap),
        .busy        (busy),
        .dec_lt_addr (dec_lt_addr),
        .dec_pk_type (dec_pk_type),
        .dec_flow    (dec_flow),
        .dec_arqn    (dec_arqn),
        .dec_seqn    (dec_seqn),
        .hec_ok      (hec_ok),
        .hdr_done_p  (hdr_done_p),
        .hec_err_p   (hec_err_p),
        .fec_corr_cnt(fec_corr_cnt)
    );

    always #83 clk_6M = ~clk_6M;

`ifdef RXHDR_FEC_STAT_EN
    localparam bit FEC_ON = 1'b1;
`else
    localparam bit FEC_ON = 1'b0;
`endif

    // Headers as {SEQN, ARQN, FLOW, TYPE[3:0], LT_ADDR[2:0]}; bit 0 sent first.
    localparam logic [9:0] HDR_A = {1'b1, 1'b0, 1'b1, 4'b0001, 3'd5};
    localparam logic [9:0] HDR_B = {1'b0, 1'b1, 1'b0, 4'b1010, 3'd2};
    localparam logic [9:0] HDR_C = {1'b0, 1'b1, 1'b1, 4'b0110, 3'd7};
    localparam logic [9:0] HDR_D = {1'b1, 1'b0, 1'b0, 4'b1111, 3'd1};

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   done_base;
    int   err_base;
    logic tx_s [54];

    // Count completion pulses, sampled away from the active edge.
    always @(negedge clk_6M) begin
        if (hdr_done_p === 1'b1) done_cnt++;
        if (hec_err_p === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [9:0] hdr);
        check({tag, ".lt_addr"}, 32'(dec_lt_addr), 32'(hdr[2:0]));
        check({tag, ".type"},    32'(dec_pk_type), 32'(hdr[6:3]));
        check({tag, ".flow"},    32'(dec_flow),    32'(hdr[7]));
        check({tag, ".arqn"},    32'(dec_arqn),    32'(hdr[8]));
        check({tag, ".seqn"},    32'(dec_seqn),    32'(hdr[9]));
    endtask

    // Transmit model: HEC over 10 bits seeded with u, HEC sent MSB first,
    // optional whitening, each bit tripled. mode 1 flips the middle sample of
    // every triplet; mode 2 flips the first two samples of triplet ftrip.
    task automatic prep(input logic [9:0] hdr, input logic [7:0] u, input logic [5:0] seed,
                        input logic wen, input int mode, input int ftrip);
        logic [7:0]  h;
        logic [6:0]  w;
        logic [17:0] d;
        logic        fb;
        logic        b;
        h = u;
        for (int k = 0; k < 10; k++) begin
            fb = h[7] ^ hdr[k];
            h  = {h[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
            d[k] = hdr[k];
        end
        for (int j = 0; j < 8; j++) d[10 + j] = h[7 - j];
        w = {seed, 1'b1};
        for (int k = 0; k < 18; k++) begin
            b = d[k] ^ (wen & w[6]);
            w = {w[5:0], 1'b0} ^ (w[6] ? 7'h11 : 7'h00);
            for (int s = 0; s < 3; s++) tx_s[3 * k + s] = b;
            if (mode == 1) tx_s[3 * k + 1] = ~b;
            if (mode == 2 && k == ftrip) begin
                tx_s[3 * k]     = ~b;
                tx_s[3 * k + 1] = ~b;
            end
        end
    endtask

    // One bit strobe every six clocks; rxbit is garbage while p_1us is low.
    task automatic strobe(input logic b, input logic st);
        @(negedge clk_6M);
        p_1us = 1'b1; rxbit = b; hdr_start_p = st;
        @(negedge clk_6M);
        p_1us = 1'b0; rxbit = ~b; hdr_start_p = 1'b0;
        repeat (4) @(negedge clk_6M);
    endtask

    // Start strobe, then scramble the sampled-at-start inputs.
    task automatic start_hdr(input logic [7:0] u, input logic [5:0] seed, input logic wen);
        uap = u; clk_seed = seed; dewhiten_en = wen;
        strobe(1'b0, 1'b1);
        uap = ~u; clk_seed = ~seed; dewhiten_en = ~wen;
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) strobe(tx_s[i], 1'b0);
    endtask

    task automatic mark();
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    initial begin
        rst = 1'b1; p_1us = 1'b0; hdr_start_p = 1'b0; abort = 1'b0; rxbit = 1'b0;
        dewhiten_en = 1'b0; clk_seed = 6'h00; uap = 8'h00;
        repeat (3) @(negedge clk_6M);
        rst = 1'b0;
        @(negedge clk_6M);

        // Reset state
        check("rst.busy", 32'(busy), 32'd0);
        check_fields("rst", 10'd0);
        check("rst.hec_ok", 32'(hec_ok), 32'd0);
        check("rst.done_p", 32'(hdr_done_p), 32'd0);
        check("rst.err_p", 32'(hec_err_p), 32'd0);
        check("rst.fec", 32'(fec_corr_cnt), 32'd0);

        // Clean header, no whitening; verdict exactly on the 54th strobe
        prep(HDR_A, 8'h47, 6'h00, 1'b0, 0, 0);
        mark();
        start_hdr(8'h47, 6'h00, 1'b0);
        check("clean.busy_start", 32'(busy), 32'd1);
        send_range(0, 53);
        check("clean.busy_53", 32'(busy), 32'd1);
        check("clean.early_done", 32'(done_cnt - done_base), 32'd0);
        send_range(53, 54);
        check("clean.done", 32'(done_cnt - done_base), 32'd1);
        check("clean.err", 32'(err_cnt - err_base), 32'd0);
        check_fields("clean", HDR_A);
        check("clean.hec_ok", 32'(hec_ok), 32'd1);
        check("clean.busy_end", 32'(busy), 32'd0);
        check("clean.fec", 32'(fec_corr_cnt), 32'd0);

        // Same header whitened with clk_seed 2A
        prep(HDR_A, 8'h47, 6'h2A, 1'b1, 0, 0);
        mark();
        start_hdr(8'h47, 6'h2A, 1'b1);
        send_range(0, 54);
        check("wht_a.done", 32'(done_cnt - done_base), 32'd1);
        check_fields("wht_a", HDR_A);
        check("wht_a.hec_ok", 32'(hec_ok), 32'd1);

        // Different header, whitened, other UAP
        prep(HDR_B, 8'hC3, 6'h15, 1'b1, 0, 0);
        mark();
        start_hdr(8'hC3, 6'h15, 1'b1);
        send_range(0, 54);
        check("wht_b.done", 32'(done_cnt - done_base), 32'd1);
        check("wht_b.err", 32'(err_cnt - err_base), 32'd0);
        check_fields("wht_b", HDR_B);

        // One bad sample in every triplet: all corrected
        prep(HDR_C, 8'h47, 6'h2A, 1'b1, 1, 0);
        mark();
        start_hdr(8'h47, 6'h2A, 1'b1);
        send_range(0, 54);
        check("fec1.done", 32'(done_cnt - done_base), 32'd1);
        check_fields("fec1", HDR_C);
        check("fec1.hec_ok", 32'(hec_ok), 32'd1);
        check("fec1.fec", 32'(fec_corr_cnt), FEC_ON ? 32'd18 : 32'd0);

        // Two bad samples in triplet 4 (TYPE bit 1): HEC error, fields held
        prep(HDR_A, 8'h47, 6'h00, 1'b0, 2, 4);
        mark();
        start_hdr(8'h47, 6'h00, 1'b0);
        send_range(0, 54);
        check("hecerr.err", 32'(err_cnt - err_base), 32'd1);
        check("hecerr.done", 32'(done_cnt - done_base), 32'd0);
        check("hecerr.hec_ok", 32'(hec_ok), 32'd0);
        check_fields("hecerr", HDR_C);
        check("hecerr.fec", 32'(fec_corr_cnt), FEC_ON ? 32'd1 : 32'd0);

        // Abort after 20 strobes; remaining strobes land in IDLE and are ignored
        prep(HDR_D, 8'h47, 6'h00, 1'b0, 0, 0);
        mark();
        start_hdr(8'h47, 6'h00, 1'b0);
        send_range(0, 20);
        @(negedge clk_6M);
        abort = 1'b1;
        @(negedge clk_6M);
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        send_range(20, 54);
        check("abort.done", 32'(done_cnt - done_base), 32'd0);
        check("abort.err", 32'(err_cnt - err_base), 32'd0);
        check("abort.hec_ok", 32'(hec_ok), 32'd0);
        check_fields("abort", HDR_C);

        // abort together with hdr_start_p: abort wins
        @(negedge clk_6M);
        p_1us = 1'b1; hdr_start_p = 1'b1; abort = 1'b1;
        @(negedge clk_6M);
        p_1us = 1'b0; hdr_start_p = 1'b0; abort = 1'b0;
        check("abort_start.busy", 32'(busy), 32'd0);

        // Second start at strobe 30 restarts reception with new parameters
        prep(HDR_B, 8'h47, 6'h00, 1'b0, 0, 0);
        mark();
        start_hdr(8'h47, 6'h00, 1'b0);
        send_range(0, 29);
        prep(HDR_D, 8'h5A, 6'h33, 1'b1, 0, 0);
        start_hdr(8'h5A, 6'h33, 1'b1);
        send_range(0, 53);
        check("restart.early", 32'(done_cnt - done_base + err_cnt - err_base), 32'd0);
        send_range(53, 54);
        check("restart.done", 32'(done_cnt - done_base), 32'd1);
        check("restart.err", 32'(err_cnt - err_base), 32'd0);
        check_fields("restart", HDR_D);
        check("restart.hec_ok", 32'(hec_ok), 32'd1);

        // Asynchronous reset mid-header clears everything at once
        prep(HDR_A, 8'h47, 6'h00, 1'b0, 1, 0);
        start_hdr(8'h47, 6'h00, 1'b0);
        send_range(0, 10);
        #20 rst = 1'b1;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check_fields("midrst", 10'd0);
        check("midrst.hec_ok", 32'(hec_ok), 32'd0);
        check("midrst.fec", 32'(fec_corr_cnt), 32'd0);
        @(negedge clk_6M);
        rst = 1'b0;
        repeat (2) @(negedge clk_6M);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_header_decoder.md
Name: rx_header_decoder

Overview:
- Receive-side counterpart of the baseband TX header path. After the access-code trailer, it takes the 54-bit FEC-1/3 packet header from the demodulated bit stream.
- Per received bit triplet it majority-votes the decoded bit, dewhitens it, runs it through the HEC divider, and captures the LT_ADDR, TYPE, FLOW, ARQN and SEQN fields.
- It feeds link control with the decoded header fields and a HEC pass/fail indication at the start of payload.

Parameters:
- HEC_POLY, 8'hA7, low 8 bits of the HEC generator D^8+D^7+D^5+D^2+D+1.
- WHT_POLY, 7'h11, whitening taps for x^7+x^4+1 (stage 0 and stage 4 feedback).
- NBITS, 18, decoded bits per header: 10 header bits plus 8 HEC bits.

Ports:
- clk_6M  in  1  6 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- p_1us  in  1  one-cycle bit strobe, one per microsecond; all bit-level state advances only on it.
- hdr_start_p  in  1  qualified with p_1us; the next strobe carries header bit 0.
- abort  in  1  synchronous cancel, for slot end or loss of sync.
- rxbit  in  1  hard-decision received bit, valid at p_1us.
- dewhiten_en  in  1  enables dewhitening; sampled at start.
- clk_seed  in  6  CLK[6:1], sampled at start.
- uap  in  8  HEC init value (DAC/master/my UAP, selected outside), sampled at start.
- busy  out  1  high while a header is being received.
- dec_lt_addr  out  3  last committed LT_ADDR.
- dec_pk_type  out  4  last committed TYPE.
- dec_flow, dec_arqn, dec_seqn  out  1 each  last committed flags.
- hec_ok  out  1  result of the last completed header.
- hdr_done_p  out  1  one-clk_6M pulse when a header completes with a good HEC.
- hec_err_p  out  1  one-clk_6M pulse when a header completes with a bad HEC.
- fec_corr_cnt  out  5  count of triplets with a disagreeing bit (optional feature).

Behaviour:
- Reset values:
  - All outputs 0 and FSM in IDLE.
  - Whitening register 7'h00, HEC register 8'h00.
- FSM states:
  - IDLE -> HDR on hdr_start_p & p_1us. This event loads the whitening register to {clk_seed,1'b1} (stage 0 = 1, stages 6:1 = CLK6..1), loads the HEC register to uap, and clears trip_cnt, bit_idx and the shadow fields.
  - HDR collects decoded bits 0..9. HDR -> HEC when bit_idx reaches 10.
  - HEC collects decoded bits 10..17. HEC -> DONE after bit 17.
  - DONE lasts one clk_6M cycle, then returns to IDLE.
- Triplet handling:
  - trip_cnt counts 0,1,2 on each p_1us while busy.
  - On the strobe with trip_cnt==2, the decoded bit is the majority of the three samples (the two latched plus the current rxbit).
  - Decoded-bit latency is one clk_6M after the third strobe.
- Dewhitening:
  - d = maj ^ (dewhiten_en_latched & wreg[6]).
  - The whitening register advances once per decoded bit (LFSR x^7+x^4+1, shift toward stage 6).
  - It keeps running through the HEC bits as well.
- HEC divider:
  - fb = hreg[7] ^ d; hreg <= {hreg[6:0],1'b0} ^ (fb ? HEC_POLY : 0).
  - Applied for all 18 bits, so the HEC is received MSB first.
- Field capture (bits 0..9, LSB first, into shadow registers):
  - Bits 0-2 go to LT_ADDR.
  - Bits 3-6 go to TYPE.
  - Bit 7 goes to FLOW, bit 8 to ARQN, bit 9 to SEQN.
- In DONE:
  - hec_ok <= (hreg==0).
  - If the HEC is good, copy the shadow fields to the dec_* outputs and pulse hdr_done_p.
  - If the HEC is bad, keep the previous dec_* outputs and pulse hec_err_p.
- busy is 1 in HDR and HEC, and 0 in IDLE and DONE.
- Boundary conditions:
  - hdr_start_p while busy restarts reception (reload everything); no pulse is issued for the aborted header.
  - abort, in any state, goes to IDLE next clk_6M with no pulse; the dec_* outputs and hec_ok keep their values.
  - abort and hdr_start_p together: abort wins.
  - rxbit is ignored when p_1us is low, and in IDLE.
  - uap, clk_seed and dewhiten_en changing mid-header have no effect.

Optional Feature:
- Macro RXHDR_FEC_STAT_EN.
- Defined:
  - fec_corr_cnt is cleared at start.
  - It increments, saturating at 18, on each triplet whose three samples are not all equal.
  - It holds after DONE until the next start.
- Undefined: fec_corr_cnt is tied to 5'd0 and no counter logic is built.

Test Plan:
- Clean header, dewhiten_en=0, uap=8'h47, with LT_ADDR=3'd5, TYPE=4'b0001, FLOW=1, ARQN=0, SEQN=1 and the bench-model HEC, each bit tripled -> hdr_done_p once, 54 strobes after start; dec_lt_addr=5, dec_pk_type=1, hec_ok=1, busy=0 afterwards.
- Same header with whitening, clk_seed=6'h2A, dewhiten_en=1, TX whitened by the bench model -> identical decoded fields and hdr_done_p.
- Single-bit error injected in the second sample of each of 18 triplets -> fields correct, hec_ok=1, fec_corr_cnt=18 (with RXHDR_FEC_STAT_EN).
- Two samples flipped in triplet 4 (TYPE bit 1) -> hec_err_p pulses, hec_ok=0, dec_* keep the prior header's values.
- abort asserted after 20 strobes -> busy=0 next cycle, no done/err pulse, outputs unchanged.
- A new header follows immediately, or a second hdr_start_p arrives at strobe 30 -> reception restarts and completes 54 strobes after the second start.
- rst asserted mid-header -> all outputs 0 immediately.
